// File: rtl/bshift_arbiter.sv
// rtl/bshift_arbiter.sv - round-robin arbiter sharing one registered 24-bit left barrel shifter
// Three-phase transaction per request: grant/latch, shift, hold response until taken.

module barrel24 (
  input  logic [23:0] d,
  input  logic [4:0]  s,
  output logic [23:0] o
);

  logic [23:0] s1, s2, s4, s8;

  always_comb begin
    s1 = s[0] ? {d[22:0], 1'b0}   : d;
    s2 = s[1] ? {s1[21:0], 2'b0}  : s1;
    s4 = s[2] ? {s2[19:0], 4'b0}  : s2;
    s8 = s[3] ? {s4[15:0], 8'b0}  : s4;
    o  = s[4] ? {s8[7:0], 16'b0}  : s8;
  end

endmodule

module bshift_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*24-1:0]   req_data,
  input  logic [NREQ*5-1:0]    req_shamt,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [23:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);
  localparam logic [23:0]  ONES   = 24'hFFFFFF;

  state_t           state, state_nx;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant_id;
  logic             grant_any;
  logic [IDW:0]     scan;
  logic [IDW:0]     ptr_inc;
  logic [23:0]      lane_data  [NREQ];
  logic [4:0]       lane_shamt [NREQ];
  logic [23:0]      op_data;
  logic [4:0]       op_shamt;
  logic [IDW-1:0]   op_id;
  logic [23:0]      shift_o;
  logic             grant;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      lane_data[k]  = req_data[k*24 +: 24];
      lane_shamt[k] = req_shamt[k*5 +: 5];
    end
  end

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan      = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      scan = {1'b0, ptr} + (IDW+1)'(i);
      if (scan >= NREQ_W)
        scan = scan - NREQ_W;
      if (req_valid[scan[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    ptr_inc = {1'b0, grant_id} + 1'b1;
    if (ptr_inc == NREQ_W)
      ptr_inc = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any && !rst) begin
          req_ready[grant_id] = 1'b1;
          grant               = 1'b1;
          state_nx            = SHIFT;
        end
      end
      SHIFT: state_nx = RESP;
      RESP: begin
        if (rsp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  barrel24 u_barrel24 (
    .d (op_data),
    .s (op_shamt),
    .o (shift_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      op_data   <= '0;
      op_shamt  <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      if (grant) begin
        op_data  <= lane_data[grant_id];
        op_shamt <= lane_shamt[grant_id];
        op_id    <= grant_id;
        ptr      <= ptr_inc[IDW-1:0];
      end
      if (state == SHIFT) begin
        // Shift amounts past bit 23 are forced to zero here, not left to the shifter.
        rsp_data  <= (op_shamt >= 5'd24) ? 24'h000000 : shift_o;
        rsp_ovf   <= |(op_data & ~(ONES >> op_shamt));
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bshift_arbiter.sv
// tb/tb_bshift_arbiter.sv - directed vector bench for bshift_arbiter
// Vector table for single transactions plus hand sequences for fairness, backpressure and reset.

module tb_bshift_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [95:0]  req_data = '0;
  logic [19:0]  req_shamt = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [23:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic         rsp_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  bshift_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [23:0] data;
    logic [4:0]  shamt;
    logic [1:0]  exp_id;
    logic [23:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Selected lane carries the operand; others carry a decoy so a wrong lane shows up in the data.
  task automatic drive_lanes(input logic [3:0] v, input logic [1:0] sel,
                             input logic [23:0] d, input logic [4:0] s);
    for (int k = 0; k < 4; k++) begin
      req_data[k*24 +: 24] = (k == int'(sel)) ? d : 24'h5A5A5A;
      req_shamt[k*5 +: 5]  = (k == int'(sel)) ? s : 5'd7;
    end
    req_valid = v;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] onehot;
    onehot = 4'b0001 << v.exp_id;
    @(posedge clk); #1;
    drive_lanes(v.valid, v.exp_id, v.data, v.shamt);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("vec_grant", 64'(req_ready), 64'(onehot));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("vec_shift_quiet", {rsp_valid, req_ready}, 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("vec_rsp", {rsp_valid, rsp_id, rsp_ovf, rsp_data},
        {1'b1, v.exp_id, v.exp_ovf, v.exp_data});
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("vec_rsp_drop", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int gcount, rcount, quiet_rsp;
    int idcnt [4];
    logic [23:0] hold_data;

    vecs[0]  = '{4'b0001, 24'h000ABC, 5'd4,  2'd0, 24'h00ABC0, 1'b0};
    vecs[1]  = '{4'b0010, 24'hF00001, 5'd4,  2'd1, 24'h000010, 1'b1};
    vecs[2]  = '{4'b0100, 24'h000001, 5'd24, 2'd2, 24'h000000, 1'b1};
    vecs[3]  = '{4'b1000, 24'h000000, 5'd31, 2'd3, 24'h000000, 1'b0};
    vecs[4]  = '{4'b1111, 24'h123456, 5'd0,  2'd0, 24'h123456, 1'b0};
    vecs[5]  = '{4'b1000, 24'h800000, 5'd1,  2'd3, 24'h000000, 1'b1};
    vecs[6]  = '{4'b0101, 24'h000001, 5'd23, 2'd0, 24'h800000, 1'b0};
    vecs[7]  = '{4'b0101, 24'h7FFFFF, 5'd23, 2'd2, 24'h800000, 1'b1};
    vecs[8]  = '{4'b0011, 24'h0F0F0F, 5'd8,  2'd0, 24'h0F0F00, 1'b1};
    vecs[9]  = '{4'b0011, 24'h00FFFF, 5'd8,  2'd1, 24'hFFFF00, 1'b0};
    vecs[10] = '{4'b0001, 24'hABCDEF, 5'd12, 2'd0, 24'hDEF000, 1'b1};

    // Reset with requests pending: nothing may be granted during reset.
    rst = 1'b1;
    drive_lanes(4'b1111, 2'd0, 24'h000ABC, 5'd4);
    repeat (2) @(negedge clk);
    chk("reset_state", {rsp_valid, rsp_id, rsp_ovf, rsp_data, req_ready}, 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      run_vec(vecs[i]);

    // Fairness: all requesters busy, consumer always ready.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_data[k*24 +: 24] = 24'(k + 1);
      req_shamt[k*5 +: 5]  = 5'(k);
      idcnt[k] = 0;
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    gcount = 0;
    rcount = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        chk("fair_grant", 64'(req_ready), 64'(4'b0001 << (gcount % 4)));
        gcount++;
      end
      if (rsp_valid) begin
        chk("fair_rsp", {rsp_id, rsp_data},
            {2'(rcount % 4), 24'((rcount % 4 + 1) << (rcount % 4))});
        idcnt[rsp_id]++;
        rcount++;
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("fair_grants", 64'(gcount), 64'd12);
    chk("fair_results", 64'(rcount), 64'd12);
    for (int k = 0; k < 4; k++)
      chk("fair_per_id", 64'(idcnt[k]), 64'd3);

    // Backpressure: response held while every requester waits.
    do_reset();
    drive_lanes(4'b0001, 2'd0, 24'h000ABC, 5'd4);
    @(negedge clk);
    chk("bp_grant", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    drive_lanes(4'b1111, 2'd1, 24'h000777, 5'd1);
    @(negedge clk);
    chk("bp_shift_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("bp_rsp", {rsp_valid, rsp_id, rsp_ovf, rsp_data}, {1'b1, 2'd0, 1'b0, 24'h00ABC0});
    hold_data = rsp_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, rsp_id, rsp_ovf, rsp_data, req_ready},
          {1'b1, 2'd0, 1'b0, 24'h00ABC0, 4'b0000});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {rsp_valid, req_ready}, {1'b1, 4'b0000});
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_next_grant", {rsp_valid, req_ready}, {1'b0, 4'b0010});
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rsp_ready = 1'b0;

    // Reset while the shifter phase is in flight.
    do_reset();
    drive_lanes(4'b0100, 2'd2, 24'h000001, 5'd1);
    @(negedge clk);
    chk("rst_mid_grant", 64'(req_ready), 64'(4'b0100));
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_clear", {rsp_valid, rsp_data}, 64'd0);
    rsp_ready = 1'b1;
    quiet_rsp = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) quiet_rsp++;
    end
    chk("rst_mid_no_rsp", 64'(quiet_rsp), 64'd0);
    @(posedge clk); #1;
    drive_lanes(4'b1010, 2'd1, 24'h000003, 5'd2);
    @(negedge clk);
    chk("rst_mid_ptr", 64'(req_ready), 64'(4'b0010));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_rsp", {rsp_valid, rsp_id, rsp_ovf, rsp_data},
        {1'b1, 2'd1, 1'b0, 24'h00000C});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
